// File: rtl/csr_file.sv
// Architectural CSR file: single-entry speculative write buffer,
// cycle/time/instret counters and accrued FP exception flags.
module csr_file #(
  parameter int CSR_WIDTH        = 64,
  parameter int CSR_WIDTH_LOG    = 12,
  parameter int COMMIT_WIDTH_LOG = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CSR_WIDTH_LOG-1:0]    csrRdAddr_i,
  output logic [CSR_WIDTH-1:0]        csrRdData_o,
  input  logic                        csrWrEn_i,
  input  logic [CSR_WIDTH_LOG-1:0]    csrWrAddr_i,
  input  logic [CSR_WIDTH-1:0]        csrWrData_i,
  output logic                        csrWrReady_o,
  input  logic                        commitCsr_i,
  input  logic                        flush_i,
  input  logic [COMMIT_WIDTH_LOG-1:0] commitCount_i,
  input  logic [4:0]                  fflagsAcc_i,
  input  logic                        timeTick_i,
  output logic [2:0]                  frm_o
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] PEND  = 1'b1;

  localparam logic [CSR_WIDTH_LOG-1:0] A_FFLAGS  = CSR_WIDTH_LOG'(12'h001);
  localparam logic [CSR_WIDTH_LOG-1:0] A_FRM     = CSR_WIDTH_LOG'(12'h002);
  localparam logic [CSR_WIDTH_LOG-1:0] A_FCSR    = CSR_WIDTH_LOG'(12'h003);
  localparam logic [CSR_WIDTH_LOG-1:0] A_MSCR    = CSR_WIDTH_LOG'(12'h340);
  localparam logic [CSR_WIDTH_LOG-1:0] A_MEPC    = CSR_WIDTH_LOG'(12'h341);
  localparam logic [CSR_WIDTH_LOG-1:0] A_CYCLE   = CSR_WIDTH_LOG'(12'hC00);
  localparam logic [CSR_WIDTH_LOG-1:0] A_TIME    = CSR_WIDTH_LOG'(12'hC01);
  localparam logic [CSR_WIDTH_LOG-1:0] A_INSTRET = CSR_WIDTH_LOG'(12'hC02);

  logic [0:0]               state_q, state_d;
  logic [CSR_WIDTH_LOG-1:0] pAddr_q, pAddr_d;
  logic [CSR_WIDTH-1:0]     pData_q, pData_d;
  logic [4:0]               fflags_q, fflags_d;
  logic [2:0]               frm_q, frm_d;
  logic [CSR_WIDTH-1:0]     mscr_q, mscr_d;
  logic [CSR_WIDTH-1:0]     mepc_q, mepc_d;
  logic [CSR_WIDTH-1:0]     cycle_q, cycle_d;
  logic [CSR_WIDTH-1:0]     time_q, time_d;
  logic [CSR_WIDTH-1:0]     instret_q, instret_d;

  logic retire;
  logic wrFf, wrFrm, wrFcsr, wrMscr, wrMepc;

  assign retire = (state_q == PEND) && commitCsr_i;
  assign wrFf   = retire && (pAddr_q == A_FFLAGS);
  assign wrFrm  = retire && (pAddr_q == A_FRM);
  assign wrFcsr = retire && (pAddr_q == A_FCSR);
  assign wrMscr = retire && (pAddr_q == A_MSCR);
  assign wrMepc = retire && (pAddr_q == A_MEPC);

  always_comb begin
    state_d = state_q;
    pAddr_d = pAddr_q;
    pData_d = pData_q;
    if (state_q == PEND) begin
      if (commitCsr_i || flush_i)
        state_d = EMPTY;
    end else if (csrWrEn_i && !flush_i) begin
      state_d = PEND;
      pAddr_d = csrWrAddr_i;
      pData_d = csrWrData_i;
    end
  end

  // Co-retiring FP flags are younger than the CSR write, so they OR on top.
  always_comb begin
    fflags_d  = fflags_q;
    frm_d     = frm_q;
    mscr_d    = mscr_q;
    mepc_d    = mepc_q;
    if (wrFf || wrFcsr)
      fflags_d = pData_q[4:0];
    fflags_d = fflags_d | fflagsAcc_i;
    if (wrFrm)
      frm_d = pData_q[2:0];
    else if (wrFcsr)
      frm_d = pData_q[7:5];
    if (wrMscr)
      mscr_d = pData_q;
    if (wrMepc)
      mepc_d = {pData_q[CSR_WIDTH-1:1], 1'b0};
    cycle_d   = cycle_q + CSR_WIDTH'(1);
    time_d    = timeTick_i ? time_q + CSR_WIDTH'(1) : time_q;
    instret_d = instret_q + CSR_WIDTH'(commitCount_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= EMPTY;
      pAddr_q   <= '0;
      pData_q   <= '0;
      fflags_q  <= '0;
      frm_q     <= '0;
      mscr_q    <= '0;
      mepc_q    <= '0;
      cycle_q   <= '0;
      time_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pAddr_q   <= pAddr_d;
      pData_q   <= pData_d;
      fflags_q  <= fflags_d;
      frm_q     <= frm_d;
      mscr_q    <= mscr_d;
      mepc_q    <= mepc_d;
      cycle_q   <= cycle_d;
      time_q    <= time_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    csrRdData_o = '0;
    unique case (csrRdAddr_i)
      A_FFLAGS:  csrRdData_o = {{(CSR_WIDTH-5){1'b0}}, fflags_q};
      A_FRM:     csrRdData_o = {{(CSR_WIDTH-3){1'b0}}, frm_q};
      A_FCSR:    csrRdData_o = {{(CSR_WIDTH-8){1'b0}}, frm_q, fflags_q};
      A_MSCR:    csrRdData_o = mscr_q;
      A_MEPC:    csrRdData_o = mepc_q;
      A_CYCLE:   csrRdData_o = cycle_q;
      A_TIME:    csrRdData_o = time_q;
      A_INSTRET: csrRdData_o = instret_q;
      default:   csrRdData_o = '0;
    endcase
  end

  assign csrWrReady_o = (state_q == EMPTY);
  assign frm_o        = frm_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed plus randomized bench for csr_file against a
// behavioural model of the architectural CSR state.
module tb_csr_file;

  localparam int W  = 64;
  localparam int AW = 12;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] rdA;
  logic [W-1:0]  rdD;
  logic          wrEn;
  logic [AW-1:0] wrA;
  logic [W-1:0]  wrD;
  logic          wrRdy;
  logic          commit;
  logic          flush;
  logic [CW-1:0] cnt;
  logic [4:0]    acc;
  logic          tick;
  logic [2:0]    frm;

  int tests = 0;
  int fails = 0;

  logic [W-1:0]  m_cyc, m_time, m_inst, m_msc, m_mepc, m_pd;
  logic [4:0]    m_ff;
  logic [2:0]    m_frm;
  bit            m_pend;
  logic [AW-1:0] m_pa;

  logic [AW-1:0] alist [10] = '{12'h001, 12'h002, 12'h003, 12'h340,
    12'h341, 12'hC00, 12'hC01, 12'hC02, 12'h7C0, 12'h000};

  csr_file #(.CSR_WIDTH(W), .CSR_WIDTH_LOG(AW), .COMMIT_WIDTH_LOG(CW)) dut (
    .clk(clk), .reset(reset),
    .csrRdAddr_i(rdA), .csrRdData_o(rdD),
    .csrWrEn_i(wrEn), .csrWrAddr_i(wrA), .csrWrData_i(wrD),
    .csrWrReady_o(wrRdy),
    .commitCsr_i(commit), .flush_i(flush),
    .commitCount_i(cnt), .fflagsAcc_i(acc),
    .timeTick_i(tick), .frm_o(frm)
  );

  always #10 clk = ~clk;

  function automatic logic [W-1:0] m_read(logic [AW-1:0] a);
    case (a)
      12'h001: return W'(m_ff);
      12'h002: return W'(m_frm);
      12'h003: return W'({m_frm, m_ff});
      12'h340: return m_msc;
      12'h341: return m_mepc;
      12'hC00: return m_cyc;
      12'hC01: return m_time;
      12'hC02: return m_inst;
      default: return '0;
    endcase
  endfunction

  // Architectural effect of one clock edge, from the current inputs.
  task automatic mdl_step();
    logic [4:0] ff;
    if (reset) begin
      m_cyc = 0; m_time = 0; m_inst = 0; m_msc = 0; m_mepc = 0;
      m_ff = 0; m_frm = 0; m_pend = 0; m_pa = 0; m_pd = 0;
      return;
    end
    m_cyc  = m_cyc + 1;
    m_time = m_time + (tick ? 1 : 0);
    m_inst = m_inst + cnt;
    ff = m_ff;
    if (m_pend && commit) begin
      if (m_pa == 12'h001) ff = m_pd[4:0];
      if (m_pa == 12'h002) m_frm = m_pd[2:0];
      if (m_pa == 12'h003) begin
        ff = m_pd[4:0];
        m_frm = m_pd[7:5];
      end
      if (m_pa == 12'h340) m_msc = m_pd;
      if (m_pa == 12'h341) m_mepc = m_pd & ~64'd1;
    end
    m_ff = ff | acc;
    if (m_pend) begin
      if (commit || flush) m_pend = 0;
    end else if (wrEn && !flush) begin
      m_pend = 1;
      m_pa = wrA;
      m_pd = wrD;
    end
  endtask

  task automatic check(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    mdl_step();
    #1;
  endtask

  task automatic rdchk(string tag, logic [AW-1:0] a, logic [W-1:0] exp);
    rdA = a;
    #1;
    check(tag, rdD, exp);
  endtask

  task automatic mcheck_all();
    check("ready", W'(wrRdy), W'(!m_pend));
    check("frm_o", W'(frm), W'(m_frm));
    for (int i = 0; i < 10; i++) begin
      rdA = alist[i];
      #1;
      check($sformatf("rd_%h", alist[i]), rdD, m_read(alist[i]));
    end
  endtask

  task automatic idle();
    wrEn = 0; wrA = 0; wrD = 0; commit = 0; flush = 0;
    cnt = 0; acc = 0; tick = 0;
  endtask

  task automatic wr(logic [AW-1:0] a, logic [W-1:0] d);
    wrEn = 1; wrA = a; wrD = d;
    cyc();
    wrEn = 0;
  endtask

  initial begin
    idle();
    rdA = 0;
    reset = 1;
    cyc();
    cyc();
    reset = 0;
    check("rst_ready", W'(wrRdy), 1);
    check("rst_frm", W'(frm), 0);
    rdchk("rst_fflags", 12'h001, 0);
    rdchk("rst_mscratch", 12'h340, 0);
    rdchk("rst_instret", 12'hC02, 0);
    rdchk("rst_cycle", 12'hC00, 0);

    repeat (10) cyc();
    rdchk("cycle10", 12'hC00, 10);

    @(negedge clk);
    force dut.cycle_q = '1;
    m_cyc = '1;
    #1 release dut.cycle_q;
    cyc();
    rdchk("cycle_wrap", 12'hC00, 0);

    wr(12'h340, 64'hDEAD);
    check("spec_ready", W'(wrRdy), 0);
    rdchk("spec_msc", 12'h340, 0);
    commit = 1;
    cyc();
    commit = 0;
    rdchk("commit_msc", 12'h340, 64'hDEAD);
    check("commit_ready", W'(wrRdy), 1);

    wr(12'h002, 5);
    flush = 1;
    cyc();
    flush = 0;
    check("flush_frm", W'(frm), 0);
    check("flush_ready", W'(wrRdy), 1);
    wr(12'h002, 5);
    flush = 1; commit = 1;
    cyc();
    flush = 0; commit = 0;
    check("flcm_frm", W'(frm), 5);
    check("flcm_ready", W'(wrRdy), 1);

    wr(12'h003, 64'hE3);
    commit = 1;
    cyc();
    commit = 0;
    check("fcsr_frm", W'(frm), 7);
    rdchk("fcsr_ff", 12'h001, 64'h03);
    wr(12'h003, 64'hE3);
    commit = 1; acc = 5'h10;
    cyc();
    commit = 0; acc = 0;
    rdchk("acc_ff", 12'h001, 64'h13);
    rdchk("acc_fcsr", 12'h003, 64'hF3);

    cnt = 4; cyc();
    cnt = 3; cyc();
    cnt = 0; cyc();
    cnt = 1; cyc();
    cnt = 0;
    rdchk("instret8", 12'hC02, 8);
    wr(12'hC02, 64'h55);
    commit = 1;
    cyc();
    commit = 0;
    rdchk("instret_ro", 12'hC02, 8);
    rdchk("unimpl", 12'h7C0, 0);

    wr(12'h341, 64'h1235);
    wr(12'h340, 64'hBEEF);
    check("viol_ready", W'(wrRdy), 0);
    commit = 1;
    cyc();
    commit = 0;
    rdchk("viol_mepc", 12'h341, 64'h1234);
    rdchk("viol_msc", 12'h340, 64'hDEAD);

    wr(12'h340, 64'h77);
    reset = 1; commit = 1;
    cyc();
    reset = 0; commit = 0;
    check("mrst_ready", W'(wrRdy), 1);
    check("mrst_frm", W'(frm), 0);
    rdchk("mrst_msc", 12'h340, 0);
    rdchk("mrst_fcsr", 12'h003, 0);
    rdchk("mrst_cycle", 12'hC00, 0);
    mcheck_all();

    for (int n = 0; n < 400; n++) begin
      wrEn   = m_pend ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) == 0);
      wrA    = alist[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) wrA = AW'($urandom);
      wrD    = {$urandom, $urandom};
      commit = ($urandom_range(0, 2) == 0);
      flush  = ($urandom_range(0, 5) == 0);
      cnt    = CW'($urandom_range(0, 4));
      acc    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      tick   = ($urandom_range(0, 1) == 0);
      reset  = ($urandom_range(0, 99) == 0);
      cyc();
      mcheck_all();
    end
    reset = 0;
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/csr_file.md
# csr_file

Architectural CSR register file for the execute/commit boundary: the responder side of the CSR interface driven by the control ALU. It stages one speculative CSR write from execute (`csrWrEn`/`csrWrAddr`/`csrWrData`) in a single-entry pending buffer. The write retires to architectural state only when the instruction commits, and is discarded on flush. It also maintains the `cycle`, `time` and `instret` counters and accrues floating-point exception flags, and it serves combinational CSR reads to register read.

## Interface
- `CSR_WIDTH`, default 64: CSR data width. Counters are `CSR_WIDTH` bits.
- `CSR_WIDTH_LOG`, default 12: CSR address width.
- `COMMIT_WIDTH_LOG`, default 3: width of the retire count.
- `clk`  in  1  clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `csrRdAddr_i`  in  `CSR_WIDTH_LOG`  read address from register read.
- `csrRdData_o`  out  `CSR_WIDTH`  committed value at `csrRdAddr_i` (combinational).
- `csrWrEn_i`  in  1  execute write request.
- `csrWrAddr_i`  in  `CSR_WIDTH_LOG`  execute write address.
- `csrWrData_i`  in  `CSR_WIDTH`  execute write data (already merged for set/clear).
- `csrWrReady_o`  out  1  pending buffer empty; a write may be issued this cycle.
- `commitCsr_i`  in  1  the CSR instruction owning the pending write retires.
- `flush_i`  in  1  mispredict/exception recovery; discard the pending write.
- `commitCount_i`  in  `COMMIT_WIDTH_LOG`  instructions retired this cycle (0..4).
- `fflagsAcc_i`  in  5  OR of FP exception flags of the instructions retiring this cycle.
- `timeTick_i`  in  1  real-time tick.
- `frm_o`  out  3  current rounding mode, registered, to the FP units.

## Operation
- **Implemented CSRs:**
  - `fflags` 0x001 (5b).
  - `frm` 0x002 (3b).
  - `fcsr` 0x003: alias of {`frm`,`fflags`}, zero-extended.
  - `mscratch` 0x340 and `mepc` 0x341 (full width; `mepc[0]` forced to 0 on write).
  - `cycle` 0xC00, `time` 0xC01, `instret` 0xC02 (read-only).
- **Reads:**
  - Unimplemented addresses read 0. Narrow registers are zero-extended.
  - There is no forwarding from the pending buffer. Reads return committed state only, because CSR instructions are serializing at dispatch.
- **Pending buffer states:** `EMPTY` and `PEND` (valid, addr, data).
  - `EMPTY` → `PEND` on `csrWrEn_i` with `flush_i`=0.
  - `PEND` → `EMPTY` on `commitCsr_i`, which performs the architectural write at the same edge.
  - `PEND` → `EMPTY` on `flush_i`, with no write.
- **Commit write:**
  - `fflags` ← data[4:0]; `frm` ← data[2:0]; `fcsr` writes `frm` ← data[7:5] and `fflags` ← data[4:0].
  - Writes to 0xC00–0xC02 or to unimplemented addresses are discarded silently.
- **Counters:**
  - `cycle` += 1 every cycle.
  - `time` += 1 on `timeTick_i`.
  - `instret` += `commitCount_i`, zero-extended.
  - All counters wrap modulo 2^`CSR_WIDTH`.
- **fflags accrual:** `fflags` ← `fflags` | `fflagsAcc_i` every cycle.
  - On a same-cycle commit write to `fflags`/`fcsr`: `fflags` ← data[4:0] | `fflagsAcc_i`. Co-retiring FP instructions are younger than the CSR instruction.

## Timing
- **Reset:** all CSRs = 0, buffer `EMPTY`, `csrWrReady_o` = 1, `frm_o` = 0, `csrRdData_o` = 0 for every address.
- **Write-to-visible latency:** a write issued at cycle N and committed at cycle M (M ≥ N+1) is readable from cycle M+1. `frm_o` updates at cycle M+1.
- **Ready:** `csrWrReady_o` = ~`PEND`, driven from the register with no combinational path from inputs.
  - `csrWrEn_i` while in `PEND` is a protocol violation; the request is ignored and the buffer contents are kept.
- **Flush and commit in the same cycle:** commit wins; the write retires and the buffer empties.
- **Flush and `csrWrEn_i` in the same cycle:** the new write is dropped.
- **`commitCsr_i` while `EMPTY`:** no architectural effect.
- **Reset mid-operation:** reset overrides commit, flush and all counter updates in that cycle.
- **Counter read timing:** reads observe the pre-edge value. `cycle` read at cycle N (N cycles after reset deasserts) returns N.

## Test plan
- **Reset values and counter wrap:**
  - Assert `reset` for 2 cycles, deassert → `csrWrReady_o` = 1, `frm_o` = 0, reads of 0x001/0x340/0xC02 = 0.
  - After 10 idle cycles, `cycle` reads 10.
  - Preload `cycle` = 2^64−1 via a force, step 1 cycle → reads 0.
- **Speculative write then commit:**
  - `csrWrEn_i`, addr 0x340, data 0xDEAD → `csrWrReady_o` = 0 next cycle; `mscratch` still reads 0.
  - Pulse `commitCsr_i` → `mscratch` reads 0xDEAD the following cycle and `csrWrReady_o` = 1.
- **Flush discard:**
  - Write 0x002 = 5, then `flush_i` → `frm_o` stays 0 and the buffer is `EMPTY`.
  - Repeat with `flush_i` and `commitCsr_i` in the same cycle → `frm_o` = 5.
- **fcsr alias and accrual:**
  - Commit write to 0x003 with data 0xE3 → `frm` = 7, `fflags` = 0x03.
  - Same cycle `fflagsAcc_i` = 0x10 → `fflags` = 0x13; 0x003 then reads 0xF3.
- **instret and read-only CSRs:**
  - `commitCount_i` = 4, 3, 0, 1 over four cycles → `instret` = 8.
  - Commit write to 0xC02 with 0x55 → `instret` unaffected.
  - Read unimplemented 0x7C0 → 0.
- **Protocol violation and mid-operation reset:**
  - A second `csrWrEn_i` while in `PEND` → original data retained and committed.
  - `reset` asserted while in `PEND` with `commitCsr_i` high → no write, everything returns to reset values.
